// File: rtl/acc_ctrl.sv
// Instruction control and 4-bit accumulator stage feeding a combinational signed ALU.
// Optional signed-overflow flag on add/sub is built only when ACC_CTRL_OVF_EN is defined.
module acc_ctrl #(
    parameter logic [3:0] ACC_RST = 4'd0,
    parameter logic [3:0] LAST_OP = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       acc_clr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [3:0] instr_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_z,
    output logic       res_n,
    output logic       res_err,
    output logic       res_ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] acc, op_q, imm_q;
    logic       err_q;
    logic       legal;
    logic       capture;

    assign legal   = (op_q <= LAST_OP);
    assign capture = instr_ready && instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // acc_clr overrides every transition, and also masks instr_ready
    // so a same-cycle instruction is never taken.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !acc_clr;
                if (instr_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (acc_clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= ACC_RST;
            op_q  <= 4'd0;
            imm_q <= 4'd0;
            err_q <= 1'b0;
        end else if (acc_clr) begin
            acc   <= ACC_RST;
            err_q <= 1'b0;
        end else begin
            if (capture) begin
                op_q  <= instr_op;
                imm_q <= instr_imm;
            end
            if (state == EXEC) begin
                if (legal) acc <= alu_out;
                err_q <= !legal;
            end
        end
    end

`ifdef ACC_CTRL_OVF_EN
    logic ovf_q, ovf_nxt;

    // Operand A is the immediate; overflow shows as a result sign unlike A's.
    always_comb begin
        ovf_nxt = 1'b0;
        case (op_q)
            4'd0:    ovf_nxt = (imm_q[3] == acc[3]) && (alu_out[3] != imm_q[3]);
            4'd1:    ovf_nxt = (imm_q[3] != acc[3]) && (alu_out[3] != imm_q[3]);
            default: ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf_q <= 1'b0;
        else if (acc_clr)        ovf_q <= 1'b0;
        else if (state == EXEC)  ovf_q <= ovf_nxt;
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    assign alu_a    = imm_q;
    assign alu_b    = acc;
    assign alu_op   = op_q;
    assign res_data = acc;
    assign res_z    = (acc == 4'd0);
    assign res_n    = acc[3];
    assign res_err  = err_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with a behavioural 4-bit ALU attached to the operand outputs.
module tb_acc_ctrl;

`ifdef ACC_CTRL_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_clr = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = 4'd0;
    logic [3:0] instr_imm = 4'd0;
    logic [3:0] alu_a, alu_b, alu_op;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_z, res_n, res_err, res_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_z(res_z), .res_n(res_n), .res_err(res_err), .res_ovf(res_ovf)
    );

    // Illegal opcodes return a distinctive value so a wrongful write is visible.
    always_comb begin
        alu_out = 4'hA;
        case (alu_op)
            4'd0: alu_out = alu_a + alu_b;
            4'd1: alu_out = alu_a - alu_b;
            4'd2: alu_out = alu_a & alu_b;
            4'd3: alu_out = alu_a | alu_b;
            4'd4: alu_out = alu_a ^ alu_b;
            4'd5: alu_out = ~alu_b;
            4'd6: alu_out = (alu_a >= 4'd4) ? 4'd0 : (alu_b <<< alu_a);
            4'd7: alu_out = (alu_a >= 4'd4) ? {4{alu_b[3]}} : 4'($signed(alu_b) >>> alu_a);
            4'd8: alu_out = alu_a;
            default: alu_out = 4'hA;
        endcase
    end

    task automatic send(input logic [3:0] op, input logic [3:0] imm);
        int k;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!instr_ready) begin
            bad++;
            $display("FAIL send_accept got instr_ready=%b need 1", instr_ready);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int k;
        k = 0;
        @(negedge clk);
        while (!res_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!res_valid) begin
            bad++;
            $display("FAIL resp_timeout got res_valid=%b need 1", res_valid);
        end
    endtask

    task automatic ack();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({instr_ready, res_valid, res_err, res_ovf, res_data, res_z, res_n} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b err=%b ovf=%b data=%h z=%b n=%b need 1 0 0 0 0 1 0",
                     instr_ready, res_valid, res_err, res_ovf, res_data, res_z, res_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Load 3 with res_ready held high: result visible after exactly two edges.
    task automatic test_latency();
        res_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'd8; instr_imm = 4'd3;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({res_valid, instr_ready} !== 2'b00) begin
            bad++;
            $display("FAIL lat_exec got vld=%b rdy=%b need 0 0", res_valid, instr_ready);
        end
        @(negedge clk);
        total++;
        if ({res_valid, res_data, res_z, res_n, res_err} !== {1'b1, 4'h3, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL lat_resp got vld=%b data=%h z=%b n=%b err=%b need 1 3 0 0 0",
                     res_valid, res_data, res_z, res_n, res_err);
        end
        @(negedge clk);
        total++;
        if ({res_valid, instr_ready, res_data} !== {1'b0, 1'b1, 4'h3}) begin
            bad++;
            $display("FAIL lat_idle got vld=%b rdy=%b data=%h need 0 1 3", res_valid, instr_ready, res_data);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_alu();
        logic [3:0] pre [12] = '{4'h3, 4'h3, 4'h3, 4'h8, 4'h8, 4'h3, 4'h8, 4'h5, 4'hA, 4'h6, 4'h4, 4'hC};
        logic [3:0] op  [12] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd7, 4'd6, 4'd1, 4'd5, 4'd4, 4'd3, 4'd0, 4'd0};
        logic [3:0] imm [12] = '{4'h5, 4'h2, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'h0, 4'hF, 4'h9, 4'h4, 4'hC};
        logic [3:0] exp [12] = '{4'h8, 4'hF, 4'h6, 4'hE, 4'hF, 4'h0, 4'hF, 4'hA, 4'h5, 4'hF, 4'h8, 4'h8};
        logic       ov  [12] = '{OVF_ON, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OVF_ON, 1'b0, 1'b0, 1'b0, OVF_ON, 1'b0};
        for (int i = 0; i < 12; i++) begin
            send(4'd8, pre[i]);
            wait_resp();
            ack();
            send(op[i], imm[i]);
            wait_resp();
            total++;
            if ({res_data, res_z, res_n, res_err, res_ovf} !==
                {exp[i], exp[i] == 4'h0, exp[i][3], 1'b0, ov[i]}) begin
                bad++;
                $display("FAIL alu_vec%0d got data=%h z=%b n=%b err=%b ovf=%b need data=%h ovf=%b",
                         i, res_data, res_z, res_n, res_err, res_ovf, exp[i], ov[i]);
            end
            ack();
        end
    endtask

    task automatic test_illegal();
        send(4'd8, 4'd5);
        wait_resp();
        ack();
        send(4'd12, 4'd1);
        wait_resp();
        total++;
        if ({res_data, res_err, res_ovf} !== {4'h5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL illegal_op got data=%h err=%b ovf=%b need 5 1 0", res_data, res_err, res_ovf);
        end
        ack();
        total++;
        if (res_err !== 1'b1) begin
            bad++;
            $display("FAIL err_hold got err=%b need 1", res_err);
        end
        send(4'd2, 4'd4);
        wait_resp();
        total++;
        if ({res_data, res_err} !== {4'h4, 1'b0}) begin
            bad++;
            $display("FAIL legal_after got data=%h err=%b need 4 0", res_data, res_err);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        send(4'd8, 4'd6);
        wait_resp();
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'd8; instr_imm = 4'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({res_valid, instr_ready, res_data} !== {1'b1, 1'b0, 4'h6}) begin
                bad++;
                $display("FAIL stall_c%0d got vld=%b rdy=%b data=%h need 1 0 6", i, res_valid, instr_ready, res_data);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if ({res_valid, instr_ready, res_data} !== {1'b0, 1'b1, 4'h6}) begin
            bad++;
            $display("FAIL stall_release got vld=%b rdy=%b data=%h need 0 1 6", res_valid, instr_ready, res_data);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        wait_resp();
        total++;
        if (res_data !== 4'h9) begin
            bad++;
            $display("FAIL pending_accept got data=%h need 9", res_data);
        end
        ack();
        @(negedge clk);
        total++;
        if ({instr_ready, res_valid, res_data} !== {1'b1, 1'b0, 4'h9}) begin
            bad++;
            $display("FAIL single_consume got rdy=%b vld=%b data=%h need 1 0 9", instr_ready, res_valid, res_data);
        end
    endtask

    task automatic test_clear();
        // Same-cycle instruction in IDLE must be refused while acc_clr is up.
        @(negedge clk);
        acc_clr = 1'b1; instr_valid = 1'b1; instr_op = 4'd8; instr_imm = 4'd7;
        #1;
        total++;
        if (instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_gate got rdy=%b need 0", instr_ready);
        end
        @(posedge clk);
        #1 acc_clr = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({instr_ready, res_valid, res_data} !== {1'b1, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL clr_idle got rdy=%b vld=%b data=%h need 1 0 0", instr_ready, res_valid, res_data);
        end
        // Clear a pending illegal-op result.
        send(4'd8, 4'd9);
        wait_resp();
        ack();
        send(4'd13, 4'd0);
        wait_resp();
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        @(negedge clk);
        total++;
        if ({res_valid, instr_ready, res_data, res_z, res_err, res_ovf} !== {1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clr_resp got vld=%b rdy=%b data=%h z=%b err=%b ovf=%b need 0 1 0 1 0 0",
                     res_valid, instr_ready, res_data, res_z, res_err, res_ovf);
        end
    endtask

    task automatic test_rst_exec();
        send(4'd8, 4'd7);
        wait_resp();
        ack();
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'd8; instr_imm = 4'd2;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({res_data, instr_ready, res_valid} !== {4'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_async got data=%h rdy=%b vld=%b need 0 1 0", res_data, instr_ready, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({res_data, instr_ready, res_valid} !== {4'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_nowrite got data=%h rdy=%b vld=%b need 0 1 0", res_data, instr_ready, res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_alu();
        test_illegal();
        test_back_to_back();
        test_clear();
        test_rst_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1);
    end

endmodule
